// File: rtl/traffic_pkg.sv
// Shared constants for the road-lane traffic scheduler: state encoding, speed table,
// LFSR seed/taps and the fixed respawn delay.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    FREEZE   = 2'd2,
    LEVEL_UP = 2'd3
  } state_t;

  localparam int unsigned SPEED_W = 10;
  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned LFSR_W  = 8;

  localparam logic [SPEED_W-1:0] SPEED_L0 = 10'd10;
  localparam logic [SPEED_W-1:0] SPEED_L1 = 10'd25;
  localparam logic [SPEED_W-1:0] SPEED_L2 = 10'd40;

  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned RESPAWN_FIXED = 4;

  function automatic logic [SPEED_W-1:0] speed_for(input logic [LEVEL_W-1:0] lvl);
    case (lvl)
      3'd0:    speed_for = SPEED_L0;
      3'd1:    speed_for = SPEED_L1;
      default: speed_for = SPEED_L2;
    endcase
  endfunction

endpackage

// File: rtl/traffic_scheduler_if.sv
// Game-logic <-> scheduler <-> lane datapath signal bundle.
interface traffic_scheduler_if
  import traffic_pkg::*;
#(
  parameter int unsigned LANES = 4
);
  logic               start;
  logic               frog_home;
  logic               hit;
  logic [LANES-1:0]   lane_wrap;
  logic [LANES-1:0]   lane_en;
  logic [LANES-1:0]   lane_step;
  logic [SPEED_W-1:0] speed;
  logic [LEVEL_W-1:0] level;
  logic [1:0]         state;

  modport master (
    output start, frog_home, hit, lane_wrap,
    input  lane_en, lane_step, speed, level, state
  );

  modport slave (
    input  start, frog_home, hit, lane_wrap,
    output lane_en, lane_step, speed, level, state
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider with clear and enable; tick_c is high during the terminal count.
module tick_prescaler #(
  parameter int unsigned DIV = 15000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/traffic_scheduler.sv
// Road-lane sequencer: lane enables, move strobes, speed and level for the car datapaths.
// Optional TRAFFIC_RANDOM_GAP_EN: LFSR-randomised respawn gap instead of the fixed one.
module traffic_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned TICK_DIV     = 15000000,
  parameter int unsigned MAX_LEVEL    = 2,
  parameter int unsigned FREEZE_TICKS = 8
) (
  input  logic               clk_in,
  input  logic               reset_in,
  traffic_scheduler_if.slave bus
);
  localparam int unsigned CD_W = $clog2(2 * LANES + 16);
  localparam int unsigned FZ_W = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS) : 1;

  state_t             state_q, state_d;
  logic               tick_c;
  logic               presc_clr_c, presc_en_c;
  logic [CD_W-1:0]    respawn_c;
  logic [LANES-1:0]   en_q, en_d, step_q, step_d;
  logic [CD_W-1:0]    cd_q [LANES];
  logic [CD_W-1:0]    cd_d [LANES];
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [FZ_W-1:0]    fz_q, fz_d;

  assign presc_clr_c = (state_q == IDLE) || (state_q == LEVEL_UP);
  assign presc_en_c  = (state_q == RUN) || (state_q == FREEZE);

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk    (clk_in),
    .rst_n  (reset_in),
    .clr    (presc_clr_c),
    .en     (presc_en_c),
    .tick_c (tick_c)
  );

`ifdef TRAFFIC_RANDOM_GAP_EN
  logic [LFSR_W-1:0] lfsr_q;

  // Shifts every cycle regardless of state so player timing perturbs the sequence
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) lfsr_q <= LFSR_SEED;
    else           lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign respawn_c = CD_W'({lfsr_q[2:0], 1'b1});
`else
  assign respawn_c = CD_W'(RESPAWN_FIXED);
`endif

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Hit takes priority over frog_home
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.start) state_d = RUN;
      RUN: begin
        if (bus.hit)            state_d = FREEZE;
        else if (bus.frog_home) state_d = LEVEL_UP;
      end
      FREEZE:   if (tick_c && (fz_q == FZ_W'(FREEZE_TICKS - 1))) state_d = IDLE;
      LEVEL_UP: state_d = RUN;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    en_d    = en_q;
    step_d  = '0;
    cd_d    = cd_q;
    level_d = level_q;
    speed_d = speed_q;
    fz_d    = fz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          level_d = '0;
          speed_d = SPEED_L0;
          en_d    = '0;
          for (int unsigned i = 0; i < LANES; i++) cd_d[i] = CD_W'(2 * i + 1);
        end
      end
      RUN: begin
        if (bus.hit) begin
          fz_d = '0;
        end else if (!bus.frog_home) begin
          // A lane enabled by this tick steps only from the next tick on
          for (int unsigned i = 0; i < LANES; i++) begin
            if (en_q[i]) begin
              if (bus.lane_wrap[i]) begin
                en_d[i] = 1'b0;
                cd_d[i] = respawn_c;
              end else begin
                step_d[i] = tick_c;
              end
            end else if (tick_c) begin
              if (cd_q[i] <= CD_W'(1)) en_d[i] = 1'b1;
              else                     cd_d[i] = cd_q[i] - CD_W'(1);
            end
          end
        end
      end
      FREEZE: begin
        if (tick_c) begin
          if (fz_q == FZ_W'(FREEZE_TICKS - 1)) begin
            level_d = '0;
            speed_d = SPEED_L0;
            en_d    = '0;
          end else begin
            fz_d = fz_q + FZ_W'(1);
          end
        end
      end
      LEVEL_UP: begin
        level_d = (level_q >= LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : level_q + LEVEL_W'(1);
        speed_d = speed_for(level_d);
        en_d    = '0;
        for (int unsigned i = 0; i < LANES; i++) cd_d[i] = CD_W'(2 * i + 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      en_q    <= '0;
      step_q  <= '0;
      level_q <= '0;
      speed_q <= SPEED_L0;
      fz_q    <= '0;
      for (int unsigned i = 0; i < LANES; i++) cd_q[i] <= CD_W'(2 * i + 1);
    end else begin
      en_q    <= en_d;
      step_q  <= step_d;
      level_q <= level_d;
      speed_q <= speed_d;
      fz_q    <= fz_d;
      for (int unsigned i = 0; i < LANES; i++) cd_q[i] <= cd_d[i];
    end
  end

  assign bus.lane_en   = en_q;
  assign bus.lane_step = step_q;
  assign bus.level     = level_q;
  assign bus.speed     = speed_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Bench for traffic_scheduler: directed vector table, hand sequences for gap/reset,
// and randomised traffic against a rule-level reference model.
module tb_traffic_scheduler;
  localparam int TD   = 4;
  localparam int FT   = 2;
  localparam int MAXL = 2;
  localparam int NL   = 4;

`ifdef TRAFFIC_RANDOM_GAP_EN
  localparam logic [3:0] GM = 4'b1110;
`else
  localparam logic [3:0] GM = 4'b1111;
`endif

  logic clk_in   = 1'b0;
  logic reset_in = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  traffic_scheduler_if #(.LANES(NL)) bus ();

  traffic_scheduler #(
    .LANES(NL), .TICK_DIV(TD), .MAX_LEVEL(MAXL), .FREEZE_TICKS(FT)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  int         m_state, m_level, m_cyc, m_fz, m_gap;
  int         m_cd [NL];
  logic [3:0] m_en, m_step;
  logic [7:0] m_lfsr;
  bit         m_tick;

  function automatic int spd_of(input int l);
    return (l == 0) ? 10 : (l == 1) ? 25 : 40;
  endfunction

  always @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      m_state = 0; m_level = 0; m_cyc = 0; m_fz = 0;
      m_en = '0; m_step = '0; m_lfsr = 8'hA5;
      for (int i = 0; i < NL; i++) m_cd[i] = 2 * i + 1;
    end else begin
      m_tick = (m_state == 1 || m_state == 2) && (m_cyc % TD == TD - 1);
`ifdef TRAFFIC_RANDOM_GAP_EN
      m_gap = 2 * int'(m_lfsr[2:0]) + 1;
`else
      m_gap = 4;
`endif
      m_step = '0;
      case (m_state)
        0: begin
          m_cyc = 0;
          if (bus.start) begin
            m_state = 1; m_level = 0; m_en = '0;
            for (int i = 0; i < NL; i++) m_cd[i] = 2 * i + 1;
          end
        end
        1: begin
          m_cyc++;
          if (bus.hit) begin
            m_state = 2; m_fz = 0;
          end else if (bus.frog_home) begin
            m_state = 3;
          end else begin
            for (int i = 0; i < NL; i++) begin
              if (m_en[i]) begin
                if (bus.lane_wrap[i]) begin m_en[i] = 1'b0; m_cd[i] = m_gap; end
                else m_step[i] = m_tick;
              end else if (m_tick) begin
                if (m_cd[i] <= 1) m_en[i] = 1'b1;
                else m_cd[i] = m_cd[i] - 1;
              end
            end
          end
        end
        2: begin
          m_cyc++;
          if (m_tick) begin
            m_fz++;
            if (m_fz == FT) begin m_state = 0; m_level = 0; m_en = '0; end
          end
        end
        default: begin
          m_cyc = 0;
          m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
          m_en = '0;
          for (int i = 0; i < NL; i++) m_cd[i] = 2 * i + 1;
          m_state = 1;
        end
      endcase
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // ---------------- helpers ----------------
  typedef struct {
    logic st, hm, ht; logic [3:0] wr; int n;
    logic [1:0] es; logic [2:0] el; logic [9:0] esp;
    logic [3:0] een, estp, msk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic hm, input logic ht, input logic [3:0] wr,
                              input int n, input logic [1:0] es, input logic [2:0] el,
                              input logic [9:0] esp, input logic [3:0] een,
                              input logic [3:0] estp, input logic [3:0] msk);
    vec_t v;
    v.st = st; v.hm = hm; v.ht = ht; v.wr = wr; v.n = n;
    v.es = es; v.el = el; v.esp = esp; v.een = een; v.estp = estp; v.msk = msk;
    return v;
  endfunction

  function automatic logic [31:0] obs(input logic [3:0] msk);
    return {9'b0, bus.state, bus.level, bus.speed, bus.lane_en & msk, bus.lane_step & msk};
  endfunction

  function automatic logic [31:0] pack_exp(input logic [1:0] s, input logic [2:0] l,
                                           input logic [9:0] sp, input logic [3:0] en,
                                           input logic [3:0] stp);
    return {9'b0, s, l, sp, en, stp};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_in();
    bus.start = 1'b0; bus.frog_home = 1'b0; bus.hit = 1'b0; bus.lane_wrap = '0;
  endtask

  task automatic do_reset();
    clear_in();
    reset_in = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b1;
    cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    logic [31:0] rst_vec;
    rst_vec = pack_exp(2'd0, 3'd0, 10'd10, 4'b0, 4'b0);

    tbl.push_back(mk(0,0,0,4'b0000, 1, 2'd0,3'd0,10'd10, 4'b0000,4'b0000,4'hF));
    tbl.push_back(mk(1,0,0,4'b0000, 1, 2'd1,3'd0,10'd10, 4'b0000,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000, 4, 2'd1,3'd0,10'd10, 4'b0001,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000, 4, 2'd1,3'd0,10'd10, 4'b0001,4'b0001,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000, 1, 2'd1,3'd0,10'd10, 4'b0001,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000, 3, 2'd1,3'd0,10'd10, 4'b0011,4'b0001,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000,16, 2'd1,3'd0,10'd10, 4'b1111,4'b0111,4'hF));
    tbl.push_back(mk(0,0,0,4'b0001, 1, 2'd1,3'd0,10'd10, 4'b1110,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000,15, 2'd1,3'd0,10'd10, 4'b1111,4'b1110,GM));
    tbl.push_back(mk(0,0,0,4'b0000, 3, 2'd1,3'd0,10'd10, 4'b1111,4'b0000,GM));
    tbl.push_back(mk(0,0,0,4'b0010, 1, 2'd1,3'd0,10'd10, 4'b1101,4'b1101,GM));
    tbl.push_back(mk(0,1,0,4'b0000, 1, 2'd3,3'd0,10'd10, 4'b1101,4'b0000,GM));
    tbl.push_back(mk(0,0,0,4'b0000, 1, 2'd1,3'd1,10'd25, 4'b0000,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000, 4, 2'd1,3'd1,10'd25, 4'b0001,4'b0000,4'hF));
    tbl.push_back(mk(0,1,0,4'b0000, 2, 2'd1,3'd2,10'd40, 4'b0000,4'b0000,4'hF));
    tbl.push_back(mk(0,1,0,4'b0000, 2, 2'd1,3'd2,10'd40, 4'b0000,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0100, 4, 2'd1,3'd2,10'd40, 4'b0001,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000,12, 2'd1,3'd2,10'd40, 4'b0011,4'b0011,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000, 4, 2'd1,3'd2,10'd40, 4'b0111,4'b0011,4'hF));
    tbl.push_back(mk(1,0,0,4'b0000, 1, 2'd1,3'd2,10'd40, 4'b0111,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000, 7, 2'd1,3'd2,10'd40, 4'b1111,4'b0111,4'hF));
    tbl.push_back(mk(0,1,1,4'b0000, 1, 2'd2,3'd2,10'd40, 4'b1111,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000, 6, 2'd2,3'd2,10'd40, 4'b1111,4'b0000,4'hF));
    tbl.push_back(mk(0,0,0,4'b0000, 1, 2'd0,3'd0,10'd10, 4'b0000,4'b0000,4'hF));

    do_reset();
    chk("reset_values", obs(4'hF), rst_vec);

    foreach (tbl[k]) begin
      bus.start = tbl[k].st; bus.frog_home = tbl[k].hm; bus.hit = tbl[k].ht;
      bus.lane_wrap = tbl[k].wr;
      cyc();
      clear_in();
      repeat (tbl[k].n - 1) cyc();
      chk($sformatf("vec%0d", k), obs(tbl[k].msk),
          pack_exp(tbl[k].es, tbl[k].el, tbl[k].esp, tbl[k].een & tbl[k].msk,
                   tbl[k].estp & tbl[k].msk));
    end

    // Respawn gap: wrap lane 0 on a tick edge, then count cycles to re-enable
    do_reset();
    bus.start = 1'b1; cyc(); clear_in();
    repeat (7) cyc();
    chk("gap_pre_en", 32'(bus.lane_en), 32'h1);
    bus.lane_wrap = 4'b0001; cyc(); clear_in();
    chk("gap_wrap_wins", 32'({bus.lane_en[0], bus.lane_step[0]}), 32'h0);
    c = 0;
    while (c < 200 && bus.lane_en[0] !== 1'b1) begin
      cyc();
      c++;
    end
`ifdef TRAFFIC_RANDOM_GAP_EN
    chk("gap_len", 32'((c % 4 == 0) && ((c / 4) % 2 == 1) && (c / 4 <= 15)), 32'h1);
`else
    chk("gap_len", 32'(c), 32'd16);
`endif

    // Asynchronous reset mid-game, checked before the next clock edge
    do_reset();
    bus.start = 1'b1; cyc(); clear_in();
    repeat (20) cyc();
    chk("pre_rst_state", 32'(bus.state), 32'd1);
    #3 reset_in = 1'b0;
    #1 chk("async_rst", obs(4'hF), rst_vec);
    @(negedge clk_in);
    reset_in = 1'b1;
    cyc();

    // Randomised traffic against the reference model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bus.start     = ($urandom_range(0, 9) == 0);
      bus.frog_home = ($urandom_range(0, 149) == 0);
      bus.hit       = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NL; i++) bus.lane_wrap[i] = ($urandom_range(0, 11) == 0);
      cyc();
      chk($sformatf("rand@%0d", n), obs(4'hF),
          pack_exp(2'(m_state), 3'(m_level), 10'(spd_of(m_level)), m_en, m_step));
    end
    clear_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_scheduler.md
# traffic_scheduler

Central sequencer for the Frogger road lanes: it decides when each car lane is active, when each lane's car moves, and at what speed. It derives movement ticks from the 100 MHz system clock, staggers and randomises car respawns, and advances the difficulty level when the frog reaches home. It sits between the game-state logic (start, collision, frog-home events) and the per-lane car datapaths. Each car datapath consumes `lane_en`, `lane_step` and `speed`, and reports `lane_wrap` back.

## Interface
- `LANES`, 4: number of car lanes scheduled.
- `TICK_DIV`, 15000000: clock cycles per movement tick.
- `MAX_LEVEL`, 2: highest level value; level saturates here.
- `FREEZE_TICKS`, 8: ticks the road stays frozen after a collision.
- `clk_in` in 1: system clock; the block uses this single clock.
- `reset_in` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a game; honoured only in IDLE.
- `frog_home` in 1: one-cycle pulse when the frog reaches the far bank.
- `hit` in 1: one-cycle pulse when the frog collides with a car.
- `lane_wrap` in LANES: one-cycle pulse per lane when its car passes the right edge.
- `lane_en` out LANES: lane car visible/active; a lane datapath holds its start position while this is low.
- `lane_step` out LANES: one-cycle move strobe per lane.
- `speed` out 10: pixels per step.
- `level` out 3: current level.
- `state` out 2: FSM state.

## Operation
- States: IDLE=0, RUN=1, FREEZE=2, LEVEL_UP=3.
- Reset values: state=IDLE, level=0, lane_en=0, lane_step=0, prescaler=0, freeze counter=0, LFSR=8'hA5. Each lane countdown resets to 2·i+1.
- IDLE → RUN on `start`:
  - level=0, lane_en=0, prescaler=0.
  - Lane i countdown loads 2·i+1, giving staggered first spawns.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - The terminal count produces an internal tick.
  - On a tick, a disabled lane with countdown==1 sets lane_en; a disabled lane with countdown>1 decrements its countdown.
  - On a tick, an enabled lane pulses lane_step.
- `lane_wrap[i]` while lane_en[i]=1:
  - Clear lane_en[i].
  - Load the lane's countdown with the respawn delay (see Configuration).
  - `lane_wrap` on a disabled lane is ignored.
- RUN → LEVEL_UP on `frog_home`. LEVEL_UP lasts one cycle:
  - level=min(level+1, MAX_LEVEL).
  - lane_en=0, countdowns reload 2·i+1, prescaler=0.
  - Then → RUN.
- RUN → FREEZE on `hit`:
  - lane_en is held, no lane_step pulses are issued, and the prescaler keeps running.
  - After FREEZE_TICKS ticks → IDLE with level=0 and lane_en=0.
- `speed` is a function of level: 0→10, 1→25, ≥2→40.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It shifts every cycle in every state, so player timing seeds randomness.
- `start` outside IDLE is ignored. `frog_home` and `hit` outside RUN are ignored.

## Timing
- All outputs are registered.
- lane_step[i] is high exactly on the cycle after the prescaler's TICK_DIV-1 count.
- A lane enabled by a tick does not step on that tick; its first step is on the following tick.
- `lane_wrap[i]` in the same cycle as a pending step: wrap wins, and lane_step[i]=0 on the next cycle.
- `hit` and `frog_home` in the same cycle: hit wins (→ FREEZE, level unchanged).
- `hit` in the same cycle as a tick: no lane_step is issued.
- Asserting reset mid-game returns every output to its reset value immediately.
- speed and level update on the cycle after LEVEL_UP is entered.

## Configuration
- `TRAFFIC_RANDOM_GAP_EN` defined: the respawn countdown loads {LFSR[2:0],1'b1}, an odd value in the range 1..15 ticks.
- `TRAFFIC_RANDOM_GAP_EN` undefined: the respawn countdown loads the fixed value 4, the LFSR is not instantiated, and the respawn gap is deterministic.

## Structure
- Package `traffic_pkg` holds:
  - state encoding constants;
  - speed constants 10/25/40;
  - LFSR seed and taps;
  - fixed respawn delay 4.
- Sub-module `tick_prescaler` contains the counter with clear and enable and emits a one-cycle tick; it is reusable by other game timers.

## Test plan
Test parameters are TICK_DIV=4 and FREEZE_TICKS=2.

- Reset, then `start` → state=1. lane_en[0] rises on the 1st tick and lane_en[3] on the 7th. lane_step[0] first pulses on the 2nd tick.
- Lane 0 enabled, `lane_wrap[0]` pulse:
  - lane_en[0]=0 next cycle.
  - With the macro undefined, lane_en[0] re-rises after 4 ticks.
  - With the macro defined, the gap is odd and in 1..15 ticks.
- Three `frog_home` pulses → level 1, 2, 2 and speed 25, 40, 40. All lanes drop and respawn staggered after each.
- `hit` and `frog_home` in the same cycle → state=2, level unchanged, no lane_step for 2 ticks, then state=0, level=0, lane_en=0.
- Assert reset_in=0 mid-RUN, asynchronously to the clock edge → all outputs are at their reset values before the next edge.
- `start` while in RUN is ignored. `lane_wrap[2]` while lane 2 is disabled causes no countdown change.
